// File: rtl/tnew_scoreboard_pkg.sv
// rtl/tnew_scoreboard_pkg.sv - shared widths, URA constants and Tnew helpers
package tnew_scoreboard_pkg;

    localparam int URA_W = 7;
    localparam int T_W   = 2;
    localparam int CNT_W = 4;

    localparam logic [URA_W-1:0] URA_NONE    = 7'b0000000;
    localparam logic [URA_W-1:0] URA_SPECIAL = 7'b0101111;

    localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
    localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;

    typedef struct packed {
        logic [URA_W-1:0] ura;
        logic [T_W-1:0]   tnew;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{ura: URA_NONE, tnew: '0};

    function automatic logic is_tracked(input logic [URA_W-1:0] ura);
        return (ura != URA_NONE) && (ura != URA_SPECIAL);
    endfunction

    // Tnew only counts down toward "result ready"; it never wraps.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/tnew_scoreboard_md_busy_counter.sv
// rtl/tnew_scoreboard_md_busy_counter.sv - mult/div busy down-counter
module md_busy_counter
    import tnew_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic busy
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_div ? DIV_CYCLES : MULT_CYCLES;
        end else if (count_q != '0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/tnew_scoreboard.sv
// rtl/tnew_scoreboard.sv - EX/MEM/WB destination and Tnew tracker with ID stall
module tnew_scoreboard
    import tnew_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [URA_W-1:0] ID_RD_URA,
    input  logic [T_W-1:0]   ID_Tnew,
    input  logic [URA_W-1:0] ID_RS_URA,
    input  logic [URA_W-1:0] ID_RT_URA,
    input  logic [T_W-1:0]   ID_Tuse_rs,
    input  logic [T_W-1:0]   ID_Tuse_rt,
    input  logic             ID_md_use,
    input  logic             ID_md_start,
    input  logic             ID_md_div,
    input  logic             flush,
    output logic [URA_W-1:0] EX_RD_URA,
    output logic [T_W-1:0]   EX_Tnew,
    output logic [URA_W-1:0] MEM_RD_URA,
    output logic [T_W-1:0]   MEM_Tnew,
    output logic [URA_W-1:0] WB_RD_URA,
    output logic             stall,
    output logic             md_busy
);

    stage_t           ex_q;
    stage_t           mem_q;
    logic [URA_W-1:0] wb_q;
    stage_t           id_norm;
    logic             hazard_rs;
    logic             hazard_rt;
    logic             md_hazard;
    logic             md_load;

    // A source stalls only if a tracked producer will not have its result by Tuse.
    function automatic logic src_hazard(
        input logic [URA_W-1:0] src,
        input logic [T_W-1:0]   tuse,
        input stage_t           ex,
        input stage_t           mem
    );
        return is_tracked(src) &&
               (((src == ex.ura)  && (ex.tnew  > tuse)) ||
                ((src == mem.ura) && (mem.tnew > tuse)));
    endfunction

    always_comb begin
        id_norm   = STAGE_EMPTY;
        if (is_tracked(ID_RD_URA)) begin
            id_norm.ura  = ID_RD_URA;
            id_norm.tnew = ID_Tnew;
        end
        hazard_rs = src_hazard(ID_RS_URA, ID_Tuse_rs, ex_q, mem_q);
        hazard_rt = src_hazard(ID_RT_URA, ID_Tuse_rt, ex_q, mem_q);
        md_hazard = md_busy & (ID_md_use | ID_md_start);
        stall     = ~flush & (hazard_rs | hazard_rt | md_hazard);
        md_load   = ID_md_start & ~stall & ~flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= STAGE_EMPTY;
            mem_q <= STAGE_EMPTY;
            wb_q  <= URA_NONE;
        end else if (flush) begin
            ex_q  <= STAGE_EMPTY;
            mem_q <= STAGE_EMPTY;
            wb_q  <= URA_NONE;
        end else begin
            ex_q       <= stall ? STAGE_EMPTY : id_norm;
            mem_q.ura  <= ex_q.ura;
            mem_q.tnew <= sat_dec(ex_q.tnew);
            wb_q       <= mem_q.ura;
        end
    end

    // The counter ignores flush on purpose: an issued mult/div keeps running.
    md_busy_counter u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_div (ID_md_div),
        .busy     (md_busy)
    );

    assign EX_RD_URA  = ex_q.ura;
    assign EX_Tnew    = ex_q.tnew;
    assign MEM_RD_URA = mem_q.ura;
    assign MEM_Tnew   = mem_q.tnew;
    assign WB_RD_URA  = wb_q;

endmodule

// File: tb/tb_tnew_scoreboard.sv
// tb/tb_tnew_scoreboard.sv - directed scoreboard bench for tnew_scoreboard
module tb_tnew_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] id_rd, id_rs, id_rt;
    logic [1:0] id_tnew, tuse_rs, tuse_rt;
    logic       md_use, md_start, md_div, flush;
    logic [6:0] ex_ura, mem_ura, wb_ura;
    logic [1:0] ex_tnew, mem_tnew;
    logic       stall, md_busy;

    typedef struct {
        int         idx;
        logic       stall;
        logic       busy;
        logic [6:0] ex_ura;
        logic [1:0] ex_tnew;
        logic [6:0] mem_ura;
        logic [1:0] mem_tnew;
        logic [6:0] wb_ura;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_idx = 0;

    tnew_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .ID_RD_URA   (id_rd),
        .ID_Tnew     (id_tnew),
        .ID_RS_URA   (id_rs),
        .ID_RT_URA   (id_rt),
        .ID_Tuse_rs  (tuse_rs),
        .ID_Tuse_rt  (tuse_rt),
        .ID_md_use   (md_use),
        .ID_md_start (md_start),
        .ID_md_div   (md_div),
        .flush       (flush),
        .EX_RD_URA   (ex_ura),
        .EX_Tnew     (ex_tnew),
        .MEM_RD_URA  (mem_ura),
        .MEM_Tnew    (mem_tnew),
        .WB_RD_URA   (wb_ura),
        .stall       (stall),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [6:0] act, input logic [6:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %0h, expected %0h", idx, name, act, req);
        end
    endtask

    // Drive one cycle of ID inputs and queue the outputs expected during that cycle.
    task automatic vec(
        input logic [6:0] rd, input logic [1:0] tn,
        input logic [6:0] rs, input logic [1:0] urs,
        input logic [6:0] rt, input logic [1:0] urt,
        input logic mu, input logic ms, input logic md, input logic fl,
        input logic e_stall, input logic e_busy,
        input logic [6:0] e_ex, input logic [1:0] e_ext,
        input logic [6:0] e_mem, input logic [1:0] e_memt,
        input logic [6:0] e_wb
    );
        exp_t e;
        @(posedge clk);
        #1;
        id_rd = rd; id_tnew = tn; id_rs = rs; tuse_rs = urs; id_rt = rt; tuse_rt = urt;
        md_use = mu; md_start = ms; md_div = md; flush = fl;
        e.idx = vec_idx; e.stall = e_stall; e.busy = e_busy;
        e.ex_ura = e_ex; e.ex_tnew = e_ext; e.mem_ura = e_mem; e.mem_tnew = e_memt; e.wb_ura = e_wb;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    task automatic idle(input logic e_busy, input logic [6:0] e_ex, input logic [1:0] e_ext,
                        input logic [6:0] e_mem, input logic [1:0] e_memt, input logic [6:0] e_wb);
        vec(7'd0, 2'd0, 7'd0, 2'd0, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, e_busy, e_ex, e_ext, e_mem, e_memt, e_wb);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",    e.idx, {6'd0, stall},    {6'd0, e.stall});
                check("md_busy",  e.idx, {6'd0, md_busy},  {6'd0, e.busy});
                check("EX_RD",    e.idx, ex_ura,           e.ex_ura);
                check("EX_Tnew",  e.idx, {5'd0, ex_tnew},  {5'd0, e.ex_tnew});
                check("MEM_RD",   e.idx, mem_ura,          e.mem_ura);
                check("MEM_Tnew", e.idx, {5'd0, mem_tnew}, {5'd0, e.mem_tnew});
                check("WB_RD",    e.idx, wb_ura,           e.wb_ura);
            end
        end
    end

    initial begin : stimulus
        id_rd = '0; id_tnew = '0; id_rs = '0; id_rt = '0; tuse_rs = '0; tuse_rt = '0;
        md_use = 0; md_start = 0; md_div = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        idle(0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        // load-use: lw -> 5, consumer rs=5 Tuse 1 stalls once
        vec(7'd5, 2'd2, 7'd0, 2'd0, 7'd0, 2'd0, 0, 0, 0, 0,  0, 0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        vec(7'd9, 2'd1, 7'd5, 2'd1, 7'd0, 2'd0, 0, 0, 0, 0,  1, 0, 7'd5, 2'd2, 7'd0, 2'd0, 7'd0);
        vec(7'd9, 2'd1, 7'd5, 2'd1, 7'd0, 2'd0, 0, 0, 0, 0,  0, 0, 7'd0, 2'd0, 7'd5, 2'd1, 7'd0);
        idle(0, 7'd9, 2'd1, 7'd0, 2'd0, 7'd5);
        idle(0, 7'd0, 2'd0, 7'd9, 2'd0, 7'd0);
        // ALU chain: Tuse 1 no stall, Tuse 0 one stall
        vec(7'd8, 2'd1, 7'd0, 2'd0, 7'd0, 2'd0, 0, 0, 0, 0,  0, 0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd9);
        vec(7'd0, 2'd0, 7'd0, 2'd0, 7'd8, 2'd1, 0, 0, 0, 0,  0, 0, 7'd8, 2'd1, 7'd0, 2'd0, 7'd0);
        vec(7'd8, 2'd1, 7'd0, 2'd0, 7'd0, 2'd0, 0, 0, 0, 0,  0, 0, 7'd0, 2'd0, 7'd8, 2'd0, 7'd0);
        vec(7'd0, 2'd0, 7'd0, 2'd0, 7'd8, 2'd0, 0, 0, 0, 0,  1, 0, 7'd8, 2'd1, 7'd0, 2'd0, 7'd8);
        vec(7'd0, 2'd0, 7'd0, 2'd0, 7'd8, 2'd0, 0, 0, 0, 0,  0, 0, 7'd0, 2'd0, 7'd8, 2'd0, 7'd0);
        // URA_SPECIAL and URA_NONE are never tracked
        vec(7'h2F, 2'd2, 7'd0, 2'd0, 7'd0, 2'd0, 0, 0, 0, 0, 0, 0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd8);
        vec(7'd0, 2'd2, 7'h2F, 2'd0, 7'h2F, 2'd0, 0, 0, 0, 0, 0, 0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        idle(0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        // div start, then mflo stalls for the 10 busy cycles
        vec(7'd0, 2'd0, 7'd0, 2'd0, 7'd0, 2'd0, 1, 1, 1, 0,  0, 0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        for (int i = 0; i < 10; i++)
            vec(7'd10, 2'd1, 7'd0, 2'd0, 7'd0, 2'd0, 1, 0, 0, 0,  1, 1, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        vec(7'd10, 2'd1, 7'd0, 2'd0, 7'd0, 2'd0, 1, 0, 0, 0,  0, 0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        idle(0, 7'd10, 2'd1, 7'd0, 2'd0, 7'd0);
        // flush with lw in EX, pending stall and a running mult
        vec(7'd0, 2'd0, 7'd0, 2'd0, 7'd0, 2'd0, 0, 1, 0, 0,  0, 0, 7'd0, 2'd0, 7'd10, 2'd0, 7'd0);
        vec(7'd5, 2'd2, 7'd0, 2'd0, 7'd0, 2'd0, 0, 0, 0, 0,  0, 1, 7'd0, 2'd0, 7'd0, 2'd0, 7'd10);
        vec(7'd6, 2'd1, 7'd5, 2'd0, 7'd0, 2'd0, 0, 1, 1, 1,  0, 1, 7'd5, 2'd2, 7'd0, 2'd0, 7'd0);
        idle(1, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        idle(1, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        idle(1, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        idle(0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        // set up MEM_Tnew = 1 with counter = 3, then reset between edges
        vec(7'd0, 2'd0, 7'd0, 2'd0, 7'd0, 2'd0, 0, 1, 0, 0,  0, 0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        vec(7'd5, 2'd2, 7'd0, 2'd0, 7'd0, 2'd0, 0, 0, 0, 0,  0, 1, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);
        idle(1, 7'd5, 2'd2, 7'd0, 2'd0, 7'd0);
        vec(7'd0, 2'd0, 7'd5, 2'd0, 7'd0, 2'd0, 1, 0, 0, 0,  1, 1, 7'd0, 2'd0, 7'd5, 2'd1, 7'd0);

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_MEM_RD",   -1, mem_ura,            7'd0);
        check("async_MEM_Tnew", -1, {5'd0, mem_tnew},   7'd0);
        check("async_md_busy",  -1, {6'd0, md_busy},    7'd0);
        check("async_stall",    -1, {6'd0, stall},      7'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(0, 7'd0, 2'd0, 7'd0, 2'd0, 7'd0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drained", -1, (exp_q.size() == 0) ? 7'd1 : 7'd0, 7'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tnew_scoreboard.md
Name: tnew_scoreboard

Overview:
- Sequential hazard tracker between ID and the EX/MEM/WB pipeline registers.
- Each cycle it captures the decoded destination URA and original Tnew for the instruction leaving ID, then ages them through EX, MEM and WB.
- It feeds EX_RD_URA/EX_Tnew/MEM_RD_URA/MEM_Tnew back to the ID-stage Tnew decoder and forwarding logic.
- It computes the ID stall from Tuse/Tnew comparison and from a multiply/divide busy counter.

Parameters:
MULT_CYCLES, 5, busy cycles loaded on mult/multu start
DIV_CYCLES, 10, busy cycles loaded on div/divu start
URA_NONE, 7'b0000000, URA meaning "no GRF write / $0"; never tracked
URA_SPECIAL, 7'b0101111, URA never forwarded; treated as URA_NONE

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high
ID_RD_URA  input  7  destination URA of the ID instruction
ID_Tnew  input  2  original Tnew of the ID instruction
ID_RS_URA  input  7  source 1 URA
ID_RT_URA  input  7  source 2 URA
ID_Tuse_rs  input  2  cycles until rs is needed (0..2)
ID_Tuse_rt  input  2  cycles until rt is needed (0..2)
ID_md_use  input  1  ID instruction uses the mult/div unit or HI/LO
ID_md_start  input  1  ID instruction starts mult/div
ID_md_div  input  1  1 = div/divu, 0 = mult/multu (valid with ID_md_start)
flush  input  1  exception/eret flush from MEM
EX_RD_URA  output  7  destination URA in EX
EX_Tnew  output  2  Tnew in EX
MEM_RD_URA  output  7  destination URA in MEM
MEM_Tnew  output  2  Tnew in MEM
WB_RD_URA  output  7  destination URA in WB
stall  output  1  freeze PC/IF-ID; insert bubble in EX
md_busy  output  1  mult/div counter non-zero

Behaviour:
- Reset (asynchronous): all stage URAs = URA_NONE, all Tnew = 0, md counter = 0, so stall = 0 and md_busy = 0.
- Capture normalisation: an ID_RD_URA equal to URA_NONE or URA_SPECIAL is stored as URA_NONE with Tnew 0.
- Per-cycle advance (no flush):
  - EX <= stall ? {URA_NONE, 0} : {ID_RD_URA, ID_Tnew} (normalised).
  - MEM <= {EX_RD_URA, sat_dec(EX_Tnew)}, where sat_dec(0) = 0 and otherwise Tnew-1.
  - WB <= MEM_RD_URA.
- Data hazard, combinational; evaluated separately for src in {RS, RT}:
  - Hazard when src is not URA_NONE/URA_SPECIAL and either:
    - src == EX_RD_URA and EX_Tnew > Tuse_src, or
    - src == MEM_RD_URA and MEM_Tnew > Tuse_src.
  - EX match has priority in the sense that either match alone stalls.
  - WB never stalls; it forwards.
- md hazard: md_busy & (ID_md_use | ID_md_start).
- stall = data hazard | md hazard; forced to 0 while flush = 1.
- md counter:
  - Loads DIV_CYCLES or MULT_CYCLES on ID_md_start & ~stall & ~flush.
  - Otherwise decrements while non-zero.
  - md_busy = (counter != 0).
  - A start accepted in cycle N makes md_busy = 1 from cycle N+1 for exactly MULT_CYCLES/DIV_CYCLES cycles.
- flush (wins over stall and advance): at the next edge EX, MEM and WB become URA_NONE/0, and the ID capture is discarded.
  - A running md counter is NOT cleared; it keeps counting down.
  - An md_start presented in the flush cycle is ignored.
- Tnew arithmetic is 2-bit unsigned and never wraps below 0.
- Outputs are registered; no combinational path from ID inputs except to stall.

Decomposition:
- Shared macros file: URA width (7), URA_NONE, URA_SPECIAL, Tnew/Tuse width (2), MULT_CYCLES, DIV_CYCLES.
- One sub-module, md_busy_counter: a 4-bit down-counter with load value select, load enable and busy output.
- Stage registers and the hazard compare stay in the top module.

Test Plan:
- Load-use: lw writing URA 5 (ID_Tnew = 2) enters EX; next ID reads RS = 5 with Tuse_rs = 1 -> stall = 1 for one cycle, EX gets a bubble (EX_RD_URA = 0), MEM_Tnew = 1; next cycle stall = 0.
- ALU chain: addu to URA 8 (Tnew = 1), then consumer RT = 8 with Tuse_rt = 1 -> stall = 0; Tuse_rt = 0 (beq) -> stall = 1 for exactly one cycle.
- URA_SPECIAL/NONE: ID_RD_URA = 7'b0101111 with Tnew = 2, then consumer src = 7'b0101111, Tuse = 0 -> stall = 0, EX_RD_URA = 0.
- div: ID_md_start = 1, ID_md_div = 1 accepted -> md_busy high for 10 cycles; mflo during busy -> stall = 1 until md_busy falls, then issues.
- Flush: with lw in EX and a stall pending, assert flush -> stall = 0 that cycle; next edge EX/MEM/WB = URA 0, Tnew 0; a running md counter keeps counting.
- Async reset mid-operation: assert reset between edges while MEM_Tnew = 1 and counter = 3 -> all outputs 0 immediately, without waiting for a clock edge.
